fp16_mul_stream_ctrl: RTL and testbench

Valid/ready streaming wrapper that sits around the existing 2-stage, free-running FP16 multiplier. The multiplier has no enable and no reset.
- Accepts operand pairs from upstream and drives them straight into the multiplier.
- Tracks in-flight operations with a valid pipe matched to the multiplier latency.
- Captures products into a small result FIFO so downstream backpressure never loses data.

---
 rtl/fp16_stream_pkg.sv | 26 ++
 rtl/fp16_result_fifo.sv | 45 ++++
 rtl/fp16_mul_stream_ctrl.sv | 89 ++++++++
 tb/tb_fp16_mul_stream_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_stream_pkg.sv
// Shared types and helpers for the FP16 multiplier streaming wrapper.
// The flag classifier is used only when FP16_MUL_STREAM_FLAGS_EN is defined.
package fp16_stream_pkg;

  typedef logic [15:0] fp16_t;

  localparam logic [4:0]  EXP_MAX = 5'h1F;
  localparam fp16_t       QNAN    = 16'h7E00;
  localparam int unsigned FLAGS_W = 3;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } flags_t;

  // Classify an FP16 value into {nan, inf, zero}
  function automatic flags_t classify(input fp16_t x);
    flags_t f;
    f.nan  = (x[14:10] == EXP_MAX) && (x[9:0] != 10'd0);
    f.inf  = (x[14:10] == EXP_MAX) && (x[9:0] == 10'd0);
    f.zero = (x[14:0] == 15'd0);
    return f;
  endfunction

endpackage

// File: rtl/fp16_result_fifo.sv
// Parametric synchronous FIFO with occupancy count; storage is not reset.
module fp16_result_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fp16_mul_stream_ctrl.sv
// Valid/ready wrapper around a free-running 2-stage FP16 multiplier.
// Define FP16_MUL_STREAM_FLAGS_EN to add per-result {nan, inf, zero} flags.
module fp16_mul_stream_ctrl
  import fp16_stream_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
`ifdef FP16_MUL_STREAM_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  localparam int unsigned IW = $clog2(MUL_LATENCY + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = ((IW > CW) ? IW : CW) + 1;
`ifdef FP16_MUL_STREAM_FLAGS_EN
  localparam int unsigned DW = 16 + FLAGS_W;
`else
  localparam int unsigned DW = 16;
`endif

  logic [MUL_LATENCY-1:0] vpipe;
  logic [IW-1:0]          inflight;
  logic [CW-1:0]          count;
  logic                   fire_in;
  logic                   fire_out;
  logic                   push;
  logic [DW-1:0]          push_data;
  logic [DW-1:0]          head_data;

  assign fire_in = in_valid & in_ready;
  assign mul_a   = in_a;
  assign mul_b   = in_b;

  // Valid pipe tracks which multiplier stages hold accepted operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vpipe <= '0;
    else        vpipe <= (vpipe << 1) | MUL_LATENCY'(fire_in);
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      inflight = inflight + IW'(vpipe[i]);
    end
  end

  // Reserve a FIFO slot for every in-flight product so a push never overflows
  assign in_ready  = (SW'(count) + SW'(inflight)) < SW'(FIFO_DEPTH);
  assign out_valid = (count != '0);
  assign fire_out  = out_valid & out_ready;
  assign push      = vpipe[MUL_LATENCY-1];

`ifdef FP16_MUL_STREAM_FLAGS_EN
  assign push_data = {classify(mul_out), mul_out};
  assign out_flags = out_valid ? head_data[15+FLAGS_W:16] : '0;
`else
  assign push_data = mul_out;
`endif
  assign out_data  = head_data[15:0];

  fp16_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (fire_out),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_fp16_mul_stream_ctrl.sv
// Self-checking bench for fp16_mul_stream_ctrl: queue-based reference model,
// directed steps and randomized valid/ready traffic. Honours FP16_MUL_STREAM_FLAGS_EN.
module tb_fp16_mul_stream_ctrl;
  import fp16_stream_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_out;
  logic [15:0] mstage;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef FP16_MUL_STREAM_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  fp16_mul_stream_ctrl #(.MUL_LATENCY(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP16_MUL_STREAM_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Truncating, flush-to-zero FP16 multiply standing in for the real multiplier
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [21:0] p;
    logic [9:0]  m;
    s = a[15] ^ b[15];
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
      return 16'h7E00;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
      if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return 16'h7E00;
      return {s, 15'h7C00};
    end
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'h0000};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e = e + 1;
    end else begin
      m = p[19:10];
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0)  return {s, 15'h0000};
    return {s, e[4:0], m};
  endfunction

  function automatic logic [2:0] tb_flags(input logic [15:0] x);
    logic [2:0] f;
    f[2] = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    f[1] = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    f[0] = (x[14:0] == 15'd0);
    return f;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       r[14:10] = 5'h1F;
      1:       r[14:0]  = 15'd0;
      default: r = r;
    endcase
    return r;
  endfunction

  // Two-stage multiplier without enable or reset
  always @(posedge clk) begin
    mstage  <= fmul(mul_a, mul_b);
    mul_out <= mstage;
  end

  typedef struct {
    logic [15:0] data;
    int          avail;
  } exp_t;

  exp_t        q[$];
  logic [15:0] popped[$];
  logic [2:0]  popped_flags[$];
  int          checks = 0;
  int          failures = 0;
  logic        last_fire_in;

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, then advance the model by this cycle's handshakes
  task automatic sample();
    logic ev;
    logic fi;
    logic fo;
    ev = (q.size() > 0) && (q[0].avail <= cyc);
    chk("out_valid", 19'(out_valid), 19'(ev));
    if (ev) begin
      chk("out_data", 19'(out_data), 19'(q[0].data));
`ifdef FP16_MUL_STREAM_FLAGS_EN
      chk("out_flags", 19'(out_flags), 19'(tb_flags(q[0].data)));
`endif
    end
    chk("in_ready", 19'(in_ready), 19'(q.size() < DEPTH));
    fi = in_valid && in_ready;
    fo = out_valid && out_ready;
    if (fo) begin
      popped.push_back(out_data);
`ifdef FP16_MUL_STREAM_FLAGS_EN
      popped_flags.push_back(out_flags);
`endif
      if (q.size() > 0) q.delete(0);
    end
    if (fi) q.push_back('{data: fmul(in_a, in_b), avail: cyc + 3});
    chk("credit_bound", 19'(q.size() <= DEPTH), 19'(1));
    last_fire_in = fi;
  endtask

  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic ordy);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b1);
      guard++;
    end
    chk("drain_empty", 19'(q.size()), 19'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] b2b [8];
    logic [15:0] bpa [5];
    logic [15:0] ra;
    logic [15:0] rb;
    logic        riv;
    logic        pending;
    int          stalls;
    int          acc;
    int          guard;

    b2b = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    bpa = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 19'(out_valid), 19'(0));
`ifdef FP16_MUL_STREAM_FLAGS_EN
    chk("reset_out_flags", 19'(out_flags), 19'(0));
`endif
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("release_in_ready", 19'(in_ready), 19'(1));

    // Single operation: 1.0 * 2.0
    popped.delete();
    step(1'b1, 16'h3C00, 16'h4000, 1'b1);
    repeat (4) step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("single_count", 19'(popped.size()), 19'(1));
    if (popped.size() > 0) chk("single_data", 19'(popped[0]), 19'(16'h4000));

    // Back-to-back stream of squares
    popped.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, b2b[i], b2b[i], 1'b1);
      if (!last_fire_in) stalls++;
    end
    drain();
    chk("b2b_stalls", 19'(stalls), 19'(0));
    chk("b2b_count", 19'(popped.size()), 19'(8));
    if (popped.size() > 1) begin
      chk("b2b_first", 19'(popped[0]), 19'(16'h3C00));
      chk("b2b_second", 19'(popped[1]), 19'(16'h4400));
    end

    // Backpressure: exactly DEPTH accepted, fifth pair held until space returns
    popped.delete();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, bpa[acc], 16'h3C00, 1'b0);
      if (last_fire_in) acc++;
    end
    chk("bp_accepted", 19'(acc), 19'(4));
    guard = 0;
    while (acc < 5 && guard < 20) begin
      step(1'b1, bpa[acc], 16'h3C00, 1'b1);
      if (last_fire_in) acc++;
      guard++;
    end
    drain();
    chk("bp_count", 19'(popped.size()), 19'(5));
    if (popped.size() > 3) chk("bp_fourth", 19'(popped[3]), 19'(16'h4400));

    // Special values: Inf*0 -> qNaN, Inf*1 -> Inf
    popped.delete();
    popped_flags.delete();
    step(1'b1, 16'h7C00, 16'h0000, 1'b1);
    step(1'b1, 16'h7C00, 16'h3C00, 1'b1);
    drain();
    chk("special_count", 19'(popped.size()), 19'(2));
    if (popped.size() > 1) begin
      chk("special_nan", 19'(popped[0]), 19'(QNAN));
      chk("special_inf", 19'(popped[1]), 19'(16'h7C00));
    end
`ifdef FP16_MUL_STREAM_FLAGS_EN
    if (popped_flags.size() > 1) begin
      chk("special_nan_flags", 19'(popped_flags[0]), 19'(3'b100));
      chk("special_inf_flags", 19'(popped_flags[1]), 19'(3'b010));
    end
`endif

    // Reset with two entries queued and two in flight
    popped.delete();
    step(1'b1, 16'h4000, 16'h4000, 1'b0);
    step(1'b1, 16'h4200, 16'h4000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'h4400, 16'h4000, 1'b0);
    step(1'b1, 16'h4500, 16'h4000, 1'b0);
    in_valid = 1'b0;
    chk("pre_reset_valid", 19'(out_valid), 19'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", 19'(out_valid), 19'(0));
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("reset_no_stale", 19'(popped.size()), 19'(0));
    step(1'b1, 16'h3C00, 16'hBC00, 1'b1);
    drain();
    chk("post_reset_count", 19'(popped.size()), 19'(1));
    if (popped.size() > 0) chk("post_reset_data", 19'(popped[0]), 19'(16'hBC00));

    // Randomized traffic with held operands while stalled
    acc = 0;
    guard = 0;
    pending = 1'b0;
    riv = 1'b0;
    ra = '0;
    rb = '0;
    while (acc < 1000 && guard < 6000) begin
      if (!pending) begin
        riv = ($urandom_range(0, 3) != 0);
        ra  = rnd_fp();
        rb  = rnd_fp();
      end
      step(riv, ra, rb, ($urandom_range(0, 3) != 0));
      if (last_fire_in) acc++;
      pending = riv && !last_fire_in;
      guard++;
    end
    chk("rand_accepted", 19'(acc), 19'(1000));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
